// File: rtl/torque_ramp_controller.sv
// Soft-start command stage: turns operator run/manoeuvre/torque requests into
// ramped enable/instruction/torque for the display and motor drivers, with e-stop latch.
module torque_ramp_controller #(
    parameter int unsigned STEP_CYCLES = 12_500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       estop,
    input  logic [1:0] cmd_instruction,
    input  logic [1:0] cmd_torque,
    output logic       enable,
    output logic [1:0] instruction,
    output logic [1:0] torque,
    output logic       busy,
    output logic       fault
);

    localparam int unsigned CNT_W = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        HOLD      = 2'd2,
        RAMP_DOWN = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       torque_q, torque_d;
    logic [1:0]       instr_q, instr_d;
    logic             enable_q, enable_d;
    logic             fault_q, fault_d;
    logic             busy_q, busy_d;

    logic             in_ramp;
    logic             tick;
    logic             same;
    logic [1:0]       goal;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
        state_d  = state_q;
        cnt_d    = '0;
        torque_d = torque_q;
        instr_d  = instr_q;
        enable_d = enable_q;
        fault_d  = fault_q;

        in_ramp = (state_q == RAMP_UP) || (state_q == RAMP_DOWN);
        tick    = in_ramp && (cnt_q == CNT_LAST);
        same    = run && (cmd_instruction == instr_q);
        goal    = same ? cmd_torque : 2'd0;

        case (state_q)
            IDLE: begin
                enable_d = 1'b0;
                torque_d = 2'd0;
                if (run && (cmd_torque != 2'd0) && !fault_q) begin
                    instr_d  = cmd_instruction;
                    enable_d = 1'b1;
                    state_d  = RAMP_UP;
                end
            end
            RAMP_UP: begin
                // Reaching the goal is checked before the tick so torque never overshoots.
                if (!same || (goal < torque_q)) begin
                    state_d = RAMP_DOWN;
                end else if (goal == torque_q) begin
                    state_d = HOLD;
                end else if (tick && (torque_q != 2'd3)) begin
                    torque_d = 2'(torque_q + 2'd1);
                    if (torque_d == goal) state_d = HOLD;
                end
            end
            HOLD: begin
                if (goal > torque_q)      state_d = RAMP_UP;
                else if (goal < torque_q) state_d = RAMP_DOWN;
            end
            RAMP_DOWN: begin
                if (same && (goal > torque_q)) begin
                    state_d = RAMP_UP;
                end else if (tick) begin
                    if (torque_q != 2'd0) torque_d = 2'(torque_q - 2'd1);
                    if (torque_d == 2'd0) begin
                        state_d  = IDLE;
                        enable_d = 1'b0;
                    end else if (torque_d == goal) begin
                        state_d = HOLD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Step counter restarts on every state change and idles at 0 outside the ramps.
        if (in_ramp && (state_d == state_q)) begin
            cnt_d = tick ? '0 : CNT_W'(cnt_q + 1'b1);
        end

        if (!estop && !run) fault_d = 1'b0;

        if (estop) begin
            state_d  = IDLE;
            cnt_d    = '0;
            torque_d = 2'd0;
            enable_d = 1'b0;
            fault_d  = 1'b1;
        end

        busy_d = (state_d == RAMP_UP) || (state_d == RAMP_DOWN);
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            torque_q <= 2'd0;
            instr_q  <= 2'd0;
            enable_q <= 1'b0;
            fault_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            torque_q <= torque_d;
            instr_q  <= instr_d;
            enable_q <= enable_d;
            fault_q  <= fault_d;
            busy_q   <= busy_d;
        end
    end

    assign enable      = enable_q;
    assign instruction = instr_q;
    assign torque      = torque_q;
    assign busy        = busy_q;
    assign fault       = fault_q;

endmodule

// File: tb/tb_torque_ramp_controller.sv
// Directed self-checking bench for torque_ramp_controller with STEP_CYCLES=4.
module tb_torque_ramp_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic       estop;
    logic [1:0] cmd_instruction;
    logic [1:0] cmd_torque;
    logic       enable;
    logic [1:0] instruction;
    logic [1:0] torque;
    logic       busy;
    logic       fault;

    int checks = 0;
    int errors = 0;

    torque_ramp_controller #(.STEP_CYCLES(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .run             (run),
        .estop           (estop),
        .cmd_instruction (cmd_instruction),
        .cmd_torque      (cmd_torque),
        .enable          (enable),
        .instruction     (instruction),
        .torque          (torque),
        .busy            (busy),
        .fault           (fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, actual, expected, $time);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last edge.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic en, input logic [1:0] ins,
                             input logic [1:0] tq, input logic bsy, input logic flt);
        check({tag, ".enable"},      8'(enable),      8'(en));
        check({tag, ".instruction"}, 8'(instruction), 8'(ins));
        check({tag, ".torque"},      8'(torque),      8'(tq));
        check({tag, ".busy"},        8'(busy),        8'(bsy));
        check({tag, ".fault"},       8'(fault),       8'(flt));
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; estop = 1'b0;
        cmd_instruction = 2'b00; cmd_torque = 2'd0;
        cyc(2);
        check_out("reset", 1'b0, 2'b00, 2'd0, 1'b0, 1'b0);
        rst = 1'b0;

        // Forward start to torque 3: request applied at edge 0, sampled at edge 1.
        run = 1'b1; cmd_instruction = 2'b00; cmd_torque = 2'd3;
        cyc(1);  check_out("start_e1", 1'b1, 2'b00, 2'd0, 1'b1, 1'b0);
        cyc(3);  check("fwd_e4.torque", 8'(torque), 8'd0);
        cyc(1);  check("fwd_e5.torque", 8'(torque), 8'd1);
        cyc(4);  check("fwd_e9.torque", 8'(torque), 8'd2);
        cyc(4);  check_out("fwd_e13_hold", 1'b1, 2'b00, 2'd3, 1'b0, 1'b0);
        cyc(2);  check_out("fwd_hold_stay", 1'b1, 2'b00, 2'd3, 1'b0, 1'b0);

        // Reversal: ramp down through IDLE, then restart in reverse.
        cmd_instruction = 2'b01;
        cyc(1);  check_out("rev_down_start", 1'b1, 2'b00, 2'd3, 1'b1, 1'b0);
        cyc(4);  check("rev_t2", 8'(torque), 8'd2);
        cyc(4);  check("rev_t1", 8'(torque), 8'd1);
        cyc(4);  check_out("rev_idle", 1'b0, 2'b00, 2'd0, 1'b0, 1'b0);
        cyc(1);  check_out("rev_restart", 1'b1, 2'b01, 2'd0, 1'b1, 1'b0);
        cyc(12); check_out("rev_hold3", 1'b1, 2'b01, 2'd3, 1'b0, 1'b0);

        // Partial reduction 3 -> 1, then back up to 2.
        cmd_torque = 2'd1;
        cyc(1);  check("part_busy", 8'(busy), 8'd1);
        cyc(4);  check("part_t2", 8'(torque), 8'd2);
        cyc(4);  check_out("part_hold1", 1'b1, 2'b01, 2'd1, 1'b0, 1'b0);
        cyc(3);  check_out("part_hold1_stay", 1'b1, 2'b01, 2'd1, 1'b0, 1'b0);
        cmd_torque = 2'd2;
        cyc(1);  check_out("part_up", 1'b1, 2'b01, 2'd1, 1'b1, 1'b0);
        cyc(3);  check("part_up_e3", 8'(torque), 8'd1);
        cyc(1);  check_out("part_hold2", 1'b1, 2'b01, 2'd2, 1'b0, 1'b0);

        // Drop run: ramp 2 -> 0 and return to IDLE.
        run = 1'b0;
        cyc(1);  check("stop_busy", 8'(busy), 8'd1);
        cyc(8);  check_out("stop_idle", 1'b0, 2'b01, 2'd0, 1'b0, 1'b0);

        // E-stop during RAMP_UP at torque 1.
        run = 1'b1; cmd_instruction = 2'b00; cmd_torque = 2'd3;
        cyc(1);  check_out("es_start", 1'b1, 2'b00, 2'd0, 1'b1, 1'b0);
        cyc(4);  check("es_t1", 8'(torque), 8'd1);
        cyc(1);
        estop = 1'b1;
        cyc(1);  check_out("es_hit", 1'b0, 2'b00, 2'd0, 1'b0, 1'b1);
        estop = 1'b0;
        cyc(3);  check_out("es_no_restart", 1'b0, 2'b00, 2'd0, 1'b0, 1'b1);
        run = 1'b0;
        cyc(1);  check_out("es_clear", 1'b0, 2'b00, 2'd0, 1'b0, 1'b0);
        run = 1'b1;
        cyc(1);  check_out("es_restart", 1'b1, 2'b00, 2'd0, 1'b1, 1'b0);
        cyc(3);  check("es_restart_e3", 8'(torque), 8'd0);
        cyc(1);  check("es_restart_t1", 8'(torque), 8'd1);

        // Back to IDLE, then zero-torque and no-run requests must not start.
        run = 1'b0;
        cyc(5);  check_out("zr_idle", 1'b0, 2'b00, 2'd0, 1'b0, 1'b0);
        run = 1'b1; cmd_torque = 2'd0;
        cyc(3);  check_out("zero_req", 1'b0, 2'b00, 2'd0, 1'b0, 1'b0);
        run = 1'b0; cmd_torque = 2'd3;
        cyc(3);  check_out("norun_req", 1'b0, 2'b00, 2'd0, 1'b0, 1'b0);

        // Reset during RAMP_DOWN at torque 2.
        run = 1'b1; cmd_instruction = 2'b10;
        cyc(1);  check_out("rst_start", 1'b1, 2'b10, 2'd0, 1'b1, 1'b0);
        cyc(12); check_out("rst_hold3", 1'b1, 2'b10, 2'd3, 1'b0, 1'b0);
        cmd_torque = 2'd0;
        cyc(5);  check_out("rst_down_t2", 1'b1, 2'b10, 2'd2, 1'b1, 1'b0);
        rst = 1'b1;
        cyc(1);  check_out("rst_mid", 1'b0, 2'b00, 2'd0, 1'b0, 1'b0);
        rst = 1'b0; cmd_torque = 2'd2; cmd_instruction = 2'b11;
        cyc(1);  check_out("rst_after", 1'b1, 2'b11, 2'd0, 1'b1, 1'b0);
        cyc(4);  check("rst_after_t1", 8'(torque), 8'd1);
        cyc(4);  check_out("rst_after_hold2", 1'b1, 2'b11, 2'd2, 1'b0, 1'b0);

        // Reset wins over a simultaneous e-stop.
        rst = 1'b1; estop = 1'b1;
        cyc(1);  check_out("rst_over_estop", 1'b0, 2'b00, 2'd0, 1'b0, 1'b0);
        rst = 1'b0;
        cyc(1);  check("estop_after_rst.fault", 8'(fault), 8'd1);
        estop = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
